// File: rtl/ixc_clkgen_if.sv
// Generated design-clock bundle: divided clock, edge strobes, design reset and cycle counter.
// No valid/ready handshake: clk_rise/clk_fall each qualify exactly one reference cycle and are never both high.
interface ixc_clkgen_if #(
    parameter int CNT_W = 64
);
    logic             clk_out;
    logic             clk_rise;
    logic             clk_fall;
    logic             rst_out;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output clk_out,
        output clk_rise,
        output clk_fall,
        output rst_out,
        output cycle_cnt
    );

    modport slave (
        input clk_out,
        input clk_rise,
        input clk_fall,
        input rst_out,
        input cycle_cnt
    );
endinterface

// File: rtl/ixc_clkgen.sv
// Divides the reference clock into a design clock with edge strobes, a rise counter and
// a power-on design reset released after RESET_CYCLES design-clock rises.
module ixc_clkgen #(
    parameter int HALF_PERIOD  = 1,
    parameter int RESET_CYCLES = 256,
    parameter int CNT_W        = 64
) (
    input  logic        clock,
    input  logic        reset,
    ixc_clkgen_if.master gen,
    output logic [31:0] dbg_ph
);
    localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int RC_W  = $clog2(RESET_CYCLES + 1);
    localparam int CMP_W = (CNT_W > RC_W) ? CNT_W : RC_W;

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(HALF_PERIOD - 1);
    localparam logic [CMP_W-1:0] RC_CMP  = CMP_W'(RESET_CYCLES);

    logic [PH_W-1:0]  ph_q, ph_d;
    logic             clk_out_q, clk_out_d;
    logic             clk_rise_q, clk_rise_d;
    logic             clk_fall_q, clk_fall_d;
    logic             rst_out_q, rst_out_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        ph_d        = ph_q;
        clk_out_d   = clk_out_q;
        clk_rise_d  = 1'b0;
        clk_fall_d  = 1'b0;
        rst_out_d   = rst_out_q;
        cycle_cnt_d = cycle_cnt_q;
        if (ph_q == PH_LAST) begin
            ph_d       = '0;
            clk_out_d  = ~clk_out_q;
            clk_rise_d = ~clk_out_q;
            clk_fall_d = clk_out_q;
            if (!clk_out_q) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                // Compared on the new count, zero-extended so an unreachable target never matches.
                // Release is sticky: later wraps of the counter cannot re-assert it.
                if (CMP_W'(cycle_cnt_d) == RC_CMP) begin
                    rst_out_d = 1'b0;
                end
            end
        end else begin
            ph_d = ph_q + PH_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ph_q        <= '0;
            clk_out_q   <= 1'b0;
            clk_rise_q  <= 1'b0;
            clk_fall_q  <= 1'b0;
            rst_out_q   <= 1'b1;
            cycle_cnt_q <= '0;
        end else begin
            ph_q        <= ph_d;
            clk_out_q   <= clk_out_d;
            clk_rise_q  <= clk_rise_d;
            clk_fall_q  <= clk_fall_d;
            rst_out_q   <= rst_out_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign gen.clk_out   = clk_out_q;
    assign gen.clk_rise  = clk_rise_q;
    assign gen.clk_fall  = clk_fall_q;
    assign gen.rst_out   = rst_out_q;
    assign gen.cycle_cnt = cycle_cnt_q;
    assign dbg_ph        = 32'(ph_q);
endmodule

// File: tb/tb_ixc_clkgen.sv
// Bench for ixc_clkgen: four parameterisations share one reference clock, checked against
// a closed-form model driven by the number of edges since each instance's reset release.
module tb_ixc_clkgen;
    logic       clock = 1'b0;
    logic [3:0] rst_r = 4'hF;
    int         n_chk = 0;
    int         n_pass = 0;
    logic       mon_en = 1'b0;

    always #5 clock = ~clock;

    ixc_clkgen_if #(.CNT_W(64)) g0 ();
    ixc_clkgen_if #(.CNT_W(16)) g1 ();
    ixc_clkgen_if #(.CNT_W(16)) g2 ();
    ixc_clkgen_if #(.CNT_W(4))  g3 ();
    logic [31:0] ph0, ph1, ph2, ph3;

    ixc_clkgen dut0 (.clock(clock), .reset(rst_r[0]), .gen(g0.master), .dbg_ph(ph0));
    ixc_clkgen #(.HALF_PERIOD(3), .RESET_CYCLES(2), .CNT_W(16)) dut1 (
        .clock(clock), .reset(rst_r[1]), .gen(g1.master), .dbg_ph(ph1));
    ixc_clkgen #(.HALF_PERIOD(4), .RESET_CYCLES(5), .CNT_W(16)) dut2 (
        .clock(clock), .reset(rst_r[2]), .gen(g2.master), .dbg_ph(ph2));
    ixc_clkgen #(.HALF_PERIOD(2), .RESET_CYCLES(3), .CNT_W(4)) dut3 (
        .clock(clock), .reset(rst_r[3]), .gen(g3.master), .dbg_ph(ph3));

    logic [3:0]  o_clk, o_rise, o_fall, o_rst;
    logic [63:0] o_cnt [4];
    logic [31:0] o_ph  [4];

    assign o_clk  = {g3.clk_out,  g2.clk_out,  g1.clk_out,  g0.clk_out};
    assign o_rise = {g3.clk_rise, g2.clk_rise, g1.clk_rise, g0.clk_rise};
    assign o_fall = {g3.clk_fall, g2.clk_fall, g1.clk_fall, g0.clk_fall};
    assign o_rst  = {g3.rst_out,  g2.rst_out,  g1.rst_out,  g0.rst_out};
    assign o_cnt[0] = g0.cycle_cnt;
    assign o_cnt[1] = 64'(g1.cycle_cnt);
    assign o_cnt[2] = 64'(g2.cycle_cnt);
    assign o_cnt[3] = 64'(g3.cycle_cnt);
    assign o_ph[0] = ph0;
    assign o_ph[1] = ph1;
    assign o_ph[2] = ph2;
    assign o_ph[3] = ph3;

    // Edges since release per instance; -1 means the last edge was a reset edge.
    int n_q [4] = '{-1, -1, -1, -1};
    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) n_q[i] <= rst_r[i] ? -1 : n_q[i] + 1;
    end

    function automatic int hp(int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int rc(int i);
        case (i)
            0: return 256;
            1: return 2;
            2: return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int cw(int i);
        case (i)
            0: return 64;
            1: return 16;
            2: return 16;
            default: return 4;
        endcase
    endfunction

    function automatic logic [63:0] msk(int w);
        return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Toggles completed after edge n: one every hp edges, the first at edge hp-1.
    function automatic longint m_tog(int n, int i);
        return longint'((n + 1) / hp(i));
    endfunction

    function automatic longint m_rises(int n, int i);
        return (m_tog(n, i) + 1) / 2;
    endfunction

    function automatic logic m_clk(int n, int i);
        return (m_tog(n, i) % 2) == 1;
    endfunction

    function automatic logic m_edge(int n, int i);
        return (n >= 0) && (((n + 1) % hp(i)) == 0);
    endfunction

    function automatic logic m_rise(int n, int i);
        return m_edge(n, i) && ((m_tog(n, i) % 2) == 1);
    endfunction

    function automatic logic m_fall(int n, int i);
        return m_edge(n, i) && ((m_tog(n, i) % 2) == 0);
    endfunction

    function automatic logic [63:0] m_cnt(int n, int i);
        logic [63:0] r;
        r = 64'(m_rises(n, i));
        return r & msk(cw(i));
    endfunction

    function automatic logic m_rst(int n, int i);
        return m_rises(n, i) < longint'(rc(i));
    endfunction

    function automatic logic [31:0] m_ph(int n, int i);
        return 32'((n + 1) % hp(i));
    endfunction

    task automatic step(int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Every-cycle invariants: strobes exclusive, counter moves only on a rise.
    logic [63:0] prev_cnt [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
    always @(negedge clock) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                logic [63:0] exp_c;
                n_chk++;
                if ((o_rise[i] & o_fall[i]) !== 1'b0)
                    $display("FAIL strobe_excl inst%0d: rise=%b fall=%b required not both 1", i, o_rise[i], o_fall[i]);
                else n_pass++;
                if (n_q[i] < 0) exp_c = 64'd0;
                else if (o_rise[i]) exp_c = (prev_cnt[i] + 64'd1) & msk(cw(i));
                else exp_c = prev_cnt[i];
                n_chk++;
                if (o_cnt[i] !== exp_c)
                    $display("FAIL cnt_step inst%0d: got %0h expected %0h", i, o_cnt[i], exp_c);
                else n_pass++;
                prev_cnt[i] = o_cnt[i];
            end
        end
    end

    task automatic test_reset();
        rst_r = 4'hF;
        step(1);
        mon_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            step(1);
            for (int i = 0; i < 4; i++) begin
                n_chk++;
                if ({o_clk[i], o_rise[i], o_fall[i], o_rst[i]} !== 4'b0001)
                    $display("FAIL reset_flags inst%0d: clk/rise/fall/rst=%b%b%b%b required 0001",
                             i, o_clk[i], o_rise[i], o_fall[i], o_rst[i]);
                else n_pass++;
                n_chk++;
                if (o_cnt[i] !== 64'd0) $display("FAIL reset_cnt inst%0d: got %0h required 0", i, o_cnt[i]);
                else n_pass++;
                n_chk++;
                if (o_ph[i] !== 32'd0) $display("FAIL reset_ph inst%0d: got %0d required 0", i, o_ph[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hp1();
        rst_r[0] = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step(1);
            n_chk++;
            if ({o_clk[0], o_rise[0], o_fall[0]} !== ((e % 2 == 0) ? 3'b110 : 3'b001))
                $display("FAIL hp1_clk E%0d: clk/rise/fall=%b%b%b required %s", e, o_clk[0], o_rise[0], o_fall[0],
                         (e % 2 == 0) ? "110" : "001");
            else n_pass++;
            n_chk++;
            if (o_cnt[0] !== 64'(e / 2 + 1))
                $display("FAIL hp1_cnt E%0d: got %0d required %0d", e, o_cnt[0], e / 2 + 1);
            else n_pass++;
        end
    endtask

    task automatic test_hp3();
        rst_r[1] = 1'b0;
        for (int e = 0; e < 18; e++) begin
            logic xr, xf, xc;
            step(1);
            xr = (e == 2) || (e == 8) || (e == 14);
            xf = (e == 5) || (e == 11) || (e == 17);
            xc = (e >= 2 && e < 5) || (e >= 8 && e < 11) || (e >= 14 && e < 17);
            n_chk++;
            if ({o_clk[1], o_rise[1], o_fall[1]} !== {xc, xr, xf})
                $display("FAIL hp3_wave E%0d: clk/rise/fall=%b%b%b required %b%b%b", e,
                         o_clk[1], o_rise[1], o_fall[1], xc, xr, xf);
            else n_pass++;
            n_chk++;
            if (o_ph[1] !== 32'((e + 1) % 3))
                $display("FAIL hp3_ph E%0d: got %0d required %0d", e, o_ph[1], (e + 1) % 3);
            else n_pass++;
        end
    endtask

    task automatic test_defaults();
        rst_r[0] = 1'b1;
        step(2);
        rst_r[0] = 1'b0;
        for (int e = 0; e < 1511; e++) begin
            step(1);
            n_chk++;
            if (o_rst[0] !== (e < 510))
                $display("FAIL dflt_rst E%0d: got %b required %b", e, o_rst[0], (e < 510));
            else n_pass++;
            if (e == 510) begin
                n_chk++;
                if (o_cnt[0] !== 64'd256 || o_rise[0] !== 1'b1)
                    $display("FAIL dflt_release E510: cnt=%0d rise=%b required cnt=256 rise=1", o_cnt[0], o_rise[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        rst_r[2] = 1'b1;
        step(1);
        rst_r[2] = 1'b0;
        for (int e = 0; e < 7; e++) begin
            step(1);
            n_chk++;
            if (o_clk[2] !== (e >= 3)) $display("FAIL mid_pre E%0d: clk got %b required %b", e, o_clk[2], (e >= 3));
            else n_pass++;
        end
        rst_r[2] = 1'b1;
        step(1);
        n_chk++;
        if ({o_clk[2], o_rise[2], o_fall[2], o_rst[2]} !== 4'b0001 || o_cnt[2] !== 64'd0 || o_ph[2] !== 32'd0)
            $display("FAIL mid_reset E7: clk/rise/fall/rst=%b%b%b%b cnt=%0d ph=%0d required 0001 cnt=0 ph=0",
                     o_clk[2], o_rise[2], o_fall[2], o_rst[2], o_cnt[2], o_ph[2]);
        else n_pass++;
        rst_r[2] = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step(1);
            n_chk++;
            if ({o_clk[2], o_rise[2], o_fall[2]} !== {(e >= 3 && e < 7), (e == 3), (e == 7)})
                $display("FAIL mid_restart E%0d: clk/rise/fall=%b%b%b required %b%b%b", e, o_clk[2], o_rise[2],
                         o_fall[2], (e >= 3 && e < 7), (e == 3), (e == 7));
            else n_pass++;
            n_chk++;
            if (o_cnt[2] !== ((e >= 3) ? 64'd1 : 64'd0))
                $display("FAIL mid_cnt E%0d: got %0d required %0d", e, o_cnt[2], (e >= 3) ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        rst_r[3] = 1'b1;
        step(1);
        rst_r[3] = 1'b0;
        for (int e = 0; e < 76; e++) begin
            int rises;
            step(1);
            rises = (e >= 1) ? (e - 1) / 4 + 1 : 0;
            n_chk++;
            if (o_cnt[3] !== 64'(rises % 16))
                $display("FAIL wrap_cnt E%0d: got %0d required %0d", e, o_cnt[3], rises % 16);
            else n_pass++;
            n_chk++;
            if (o_rst[3] !== (rises < 3))
                $display("FAIL wrap_rst E%0d: got %b required %b", e, o_rst[3], (rises < 3));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (rst_r[i]) begin
                    if ($urandom_range(2) == 0) rst_r[i] = 1'b0;
                end else if ($urandom_range(399) == 0) begin
                    rst_r[i] = 1'b1;
                end
            end
            step(1);
            for (int i = 0; i < 4; i++) begin
                int n;
                n = n_q[i];
                n_chk++;
                if ({o_clk[i], o_rise[i], o_fall[i], o_rst[i]} !== {m_clk(n, i), m_rise(n, i), m_fall(n, i), m_rst(n, i)})
                    $display("FAIL rand_flags inst%0d n%0d: clk/rise/fall/rst=%b%b%b%b required %b%b%b%b", i, n,
                             o_clk[i], o_rise[i], o_fall[i], o_rst[i], m_clk(n, i), m_rise(n, i), m_fall(n, i), m_rst(n, i));
                else n_pass++;
                n_chk++;
                if (o_cnt[i] !== m_cnt(n, i))
                    $display("FAIL rand_cnt inst%0d n%0d: got %0h required %0h", i, n, o_cnt[i], m_cnt(n, i));
                else n_pass++;
                n_chk++;
                if (o_ph[i] !== m_ph(n, i))
                    $display("FAIL rand_ph inst%0d n%0d: got %0d required %0d", i, n, o_ph[i], m_ph(n, i));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hp1();
        test_hp3();
        test_defaults();
        test_mid_reset();
        test_wrap();
        test_random();
        step(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
